ps2_make_code_rx: RTL and testbench



---
 rtl/ps2_make_code_rx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_make_code_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_make_code_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the pins, checks 11-bit frames,
// strips break (F0 xx) and extended (E0 ...) sequences and emits plain make codes.
module ps2_make_code_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    CHECK
  } state_t;

  logic                  ps2c_meta_q, ps2c_sync_q;
  logic                  ps2d_meta_q, ps2d_sync_q;
  logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                  filt_clk_q, filt_clk_d;
  logic                  filt_clk_prev_q;
  logic                  fall_tick;

  state_t                state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic                  stop_q, stop_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  byte_ok;

  logic                  brk_q, brk_d;
  logic                  ext_q, ext_d;
  logic [7:0]            key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  frame_err_q, frame_err_d;

  // Input synchronizers and clock glitch filter; both idle high like the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_q     <= 1'b1;
      ps2c_sync_q     <= 1'b1;
      ps2d_meta_q     <= 1'b1;
      ps2d_sync_q     <= 1'b1;
      filt_sr_q       <= '1;
      filt_clk_q      <= 1'b1;
      filt_clk_prev_q <= 1'b1;
    end else begin
      ps2c_meta_q     <= ps2c;
      ps2c_sync_q     <= ps2c_meta_q;
      ps2d_meta_q     <= ps2d;
      ps2d_sync_q     <= ps2d_meta_q;
      filt_sr_q       <= filt_sr_d;
      filt_clk_q      <= filt_clk_d;
      filt_clk_prev_q <= filt_clk_q;
    end
  end

  // The window includes the newest synced sample so the level flips on the
  // FILTER_LEN-th agreeing sample rather than one cycle later.
  always_comb begin
    filt_sr_d  = {filt_sr_q[FILTER_LEN-2:0], ps2c_sync_q};
    filt_clk_d = filt_clk_q;
    if (&filt_sr_d) begin
      filt_clk_d = 1'b1;
    end else if (~|filt_sr_d) begin
      filt_clk_d = 1'b0;
    end
  end

  assign fall_tick = filt_clk_prev_q & ~filt_clk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_q       <= 1'b0;
      stop_q      <= 1'b0;
      wdog_q      <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_code_q  <= 8'h00;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      stop_q      <= stop_d;
      wdog_q      <= wdog_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame FSM; rx_en only gates the start bit, so a started frame always completes.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    stop_d      = stop_q;
    wdog_d      = wdog_q;
    byte_ok     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        wdog_d    = '0;
        bit_cnt_d = 3'd0;
        if (fall_tick && rx_en && !ps2d_sync_q) begin
          state_d = DATA;
        end
      end

      DATA, PARITY, STOP: begin
        if (fall_tick) begin
          wdog_d = '0;
          case (state_q)
            DATA: begin
              shift_d = {ps2d_sync_q, shift_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                state_d = PARITY;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
            PARITY: begin
              par_d   = ps2d_sync_q;
              state_d = STOP;
            end
            default: begin
              stop_d  = ps2d_sync_q;
              state_d = CHECK;
            end
          endcase
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          wdog_d      = '0;
          shift_d     = 8'h00;
          bit_cnt_d   = 3'd0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      CHECK: begin
        if (((^shift_q) ^ par_q) && stop_q) begin
          byte_ok = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Make/break filter: prefixes arm a flag, the byte following any prefix is swallowed.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (byte_ok) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        key_code_d  = shift_q;
        key_valid_d = 1'b1;
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_make_code_rx.sv
// Scoreboard bench for ps2_make_code_rx: directed scenarios plus random frames
// checked against a byte-level make/break model.
module tb_ps2_make_code_rx;

  localparam int FL = 8;
  localparam int TO = 400;
  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;
  logic       busy;

  ps2_make_code_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic [7:0] m_last = 8'h00;
  int exp_err = 0;
  int obs_err = 0;
  int err_cyc = 0;
  int fall_cyc = 0;
  logic busy_mid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Reference model: the keyboard byte stream rules, one accepted byte at a time.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk || m_ext) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      exp_q.push_back(b);
      m_last = b;
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit bad);
    logic p;
    p = (~^d) ^ bad;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2d = bits[i];
      repeat (HP / 2) @(negedge clk);
      ps2c = 1'b0;
      fall_cyc = cyc;
      repeat (HP) @(negedge clk);
      if (i == 1) busy_mid = busy;
      ps2c = 1'b1;
      repeat (HP / 2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad);
    if (rx_en) begin
      if (bad) exp_err++;
      else model_byte(d);
    end
    send_bits(mk(d, bad), 11);
    ps2d = 1'b1;
    repeat (3 * HP) @(negedge clk);
  endtask

  // Monitor: pops the expected code on every key_valid pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (key_valid && frame_err) check("valid_err_same_cycle", 1, 0);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", int'(key_code), -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("key_code", int'(key_code), int'(mon_e));
          check_range("valid_latency", cyc - fall_cyc, 1, FL + 5);
        end
      end
      if (frame_err) begin
        obs_err++;
        err_cyc = cyc;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    bit         bad;

    repeat (5) @(negedge clk);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h16, 1'b0);
    check("f16_busy_mid", int'(busy_mid), 1);
    check("f16_busy_after", int'(busy), 0);
    check("f16_code", int'(key_code), 8'h16);
    check("f16_no_err", obs_err, 0);

    send_frame(8'h1E, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1E, 1'b0);
    check("brk_code_holds", int'(key_code), 8'h1E);
    check("brk_queue_drained", exp_q.size(), 0);

    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_code_holds", int'(key_code), 8'h1E);
    send_frame(8'h26, 1'b0);
    check("ext_then_26", int'(key_code), 8'h26);

    send_frame(8'h45, 1'b1);
    check("par_err_count", obs_err, exp_err);
    check("par_code_unchanged", int'(key_code), 8'h26);
    send_frame(8'h45, 1'b0);
    check("par_then_45", int'(key_code), 8'h45);

    exp_err++;
    send_bits(mk(8'h3D, 1'b0), 5);
    repeat (TO + 100) @(negedge clk);
    check("timeout_err_count", obs_err, exp_err);
    check_range("timeout_delay", err_cyc - fall_cyc, TO, TO + FL + 10);
    check("timeout_busy", int'(busy), 0);
    send_frame(8'h3D, 1'b0);
    check("after_timeout_3D", int'(key_code), 8'h3D);

    for (int g = 0; g < 3; g++) begin
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      repeat (12) @(negedge clk);
      check("glitch_busy", int'(busy), 0);
    end
    check("glitch_no_err", obs_err, exp_err);

    rx_en = 1'b0;
    send_frame(8'h2A, 1'b0);
    check("rxen_busy_mid", int'(busy_mid), 0);
    rx_en = 1'b1;
    check("rxen_code_unchanged", int'(key_code), 8'h3D);

    send_bits(mk(8'h46, 1'b0), 5);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_key_code", int'(key_code), 0);
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_busy", int'(busy), 0);
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_last = 8'h00;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h46, 1'b0);
    check("midrst_then_46", int'(key_code), 8'h46);

    for (int n = 0; n < 36; n++) begin
      case ($urandom_range(0, 9))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      send_frame(rb, bad);
      check("rand_key_code", int'(key_code), int'(m_last));
    end

    check("final_err_count", obs_err, exp_err);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
